// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for the serial sequence-detector path. Words of
// WIDTH bits are accepted over a valid/ready handshake and sent out one bit per
// clock on x. A one-word holding buffer lets back-to-back words stream with no
// gap bits. While idle, x rests at 1, which is the detector's neutral level.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   din        word to serialize
//   din_valid  din holds a valid word
//   din_ready  a word can be accepted this cycle (low while reset is high)
//   x          serial bit to the detector, 1 when idle (registered)
//   x_valid    x carries a word bit this cycle (registered)
//   word_end   high during the last bit of each word (registered)
// -----------------------------------------------------------------------------
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_end
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] sreg_r;
   logic [WIDTH-1:0] hold_r;
   logic             hold_full_r;

   logic             last_s;
   logic             need_s;
   logic             acc_s;
   logic             have_word_s;
   logic [WIDTH-1:0] word_s;
   logic             store_din_s;
   logic [CW-1:0]    cnt_nxt_s;

   // Bit that goes on the line first out of a word, per the bit order.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Shift a word so that its next bit sits where first_bit() looks.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // Handshake: ready whenever the holding buffer is empty and not in reset.
   assign din_ready = !hold_full_r && !reset;

   // Decode word boundary, pick the next word source and decide whether din is buffered.
   always_comb begin
      last_s      = (state_r == SHIFT) && (cnt_r == LAST_CNT);
      need_s      = (state_r == IDLE) || last_s;
      acc_s       = din_valid && din_ready;
      cnt_nxt_s   = cnt_r + CNT_ONE;
      have_word_s = 1'b0;
      word_s      = hold_r;
      if (hold_full_r) begin
         // Buffered word always goes first so ordering is preserved.
         have_word_s = 1'b1;
         word_s      = hold_r;
      end else if (acc_s) begin
         have_word_s = 1'b1;
         word_s      = din;
      end else begin
         have_word_s = 1'b0;
         word_s      = hold_r;
      end
      // din is buffered only when it is not loaded straight into the shifter.
      if (acc_s && !(need_s && !hold_full_r)) begin
         store_din_s = 1'b1;
      end else begin
         store_din_s = 1'b0;
      end
   end

   // Serializer FSM, holding buffer and registered line outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         sreg_r      <= '0;
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         x           <= 1'b1;
         x_valid     <= 1'b0;
         word_end    <= 1'b0;
      end else begin
         if (need_s) begin
            if (have_word_s) begin
               // Load: first bit goes out next cycle, remaining bits stay in sreg.
               state_r  <= SHIFT;
               cnt_r    <= '0;
               sreg_r   <= advance(word_s);
               x        <= first_bit(word_s);
               x_valid  <= 1'b1;
               word_end <= 1'b0;
            end else begin
               state_r  <= IDLE;
               cnt_r    <= cnt_r;
               sreg_r   <= sreg_r;
               x        <= 1'b1;
               x_valid  <= 1'b0;
               word_end <= 1'b0;
            end
         end else begin
            state_r  <= SHIFT;
            cnt_r    <= cnt_nxt_s;
            sreg_r   <= advance(sreg_r);
            x        <= first_bit(sreg_r);
            x_valid  <= 1'b1;
            word_end <= (cnt_nxt_s == LAST_CNT);
         end

         // A new word cannot arrive while the buffer is full, so these never collide.
         if (need_s && hold_full_r) begin
            hold_r      <= hold_r;
            hold_full_r <= 1'b0;
         end else if (store_din_s) begin
            hold_r      <= din;
            hold_full_r <= 1'b1;
         end else begin
            hold_r      <= hold_r;
            hold_full_r <= hold_full_r;
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Self-checking bench for bit_serializer (WIDTH=8). Two instances share the
// same stimulus: one sends MSB first, the other LSB first. Single words are
// driven from a vector table; streaming, backpressure and reset corners are
// hand-written sequences. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;

   logic       m_ready, m_x, m_xv, m_we;
   logic       l_ready, l_x, l_xv, l_we;

   int n_checks;
   int n_fail;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (m_ready),
      .x         (m_x),
      .x_valid   (m_xv),
      .word_end  (m_we)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (l_ready),
      .x         (l_x),
      .x_valid   (l_xv),
      .word_end  (l_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_msb;  // bit 7 is the first bit on x
      logic [7:0] exp_lsb;  // bit 7 is the first bit on x
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, " m_x"}, m_x, 1'b1);
      check({name, " m_x_valid"}, m_xv, 1'b0);
      check({name, " m_word_end"}, m_we, 1'b0);
      check({name, " l_x"}, l_x, 1'b1);
      check({name, " l_x_valid"}, l_xv, 1'b0);
   endtask

   logic [23:0] seq;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      din       = 8'hAA;
      din_valid = 1'b1;

      // Vector table: word, expected MSB-first and LSB-first bit orders.
      vecs[0] = '{din: 8'h20, exp_msb: 8'b0010_0000, exp_lsb: 8'b0000_0100};
      vecs[1] = '{din: 8'h01, exp_msb: 8'b0000_0001, exp_lsb: 8'b1000_0000};
      vecs[2] = '{din: 8'hA5, exp_msb: 8'b1010_0101, exp_lsb: 8'b1010_0101};
      vecs[3] = '{din: 8'h96, exp_msb: 8'b1001_0110, exp_lsb: 8'b0110_1001};
      vecs[4] = '{din: 8'hFF, exp_msb: 8'b1111_1111, exp_lsb: 8'b1111_1111};
      vecs[5] = '{din: 8'h0E, exp_msb: 8'b0000_1110, exp_lsb: 8'b0111_0000};

      // ---- Reset with din_valid held high ----
      tick();
      check_idle("reset");
      check("reset m_din_ready", m_ready, 1'b0);
      tick();
      check_idle("reset2");
      check("reset2 m_din_ready", m_ready, 1'b0);
      reset     = 1'b0;
      din_valid = 1'b0;
      #1;
      check("post-reset m_din_ready", m_ready, 1'b1);
      tick();
      check_idle("post-reset no capture");

      // ---- Table-driven single words from idle ----
      for (int v = 0; v < 6; v++) begin
         din       = vecs[v].din;
         din_valid = 1'b1;
         tick();
         din_valid = 1'b0;
         din       = ~vecs[v].din;  // change after transfer must not matter
         for (int i = 0; i < 8; i++) begin
            check($sformatf("vec%0d bit%0d m_x", v, i), m_x, vecs[v].exp_msb[7-i]);
            check($sformatf("vec%0d bit%0d l_x", v, i), l_x, vecs[v].exp_lsb[7-i]);
            check($sformatf("vec%0d bit%0d x_valid", v, i), m_xv, 1'b1);
            check($sformatf("vec%0d bit%0d word_end", v, i), m_we, (i == 7));
            check($sformatf("vec%0d bit%0d l_word_end", v, i), l_we, (i == 7));
            tick();
         end
         check_idle($sformatf("vec%0d after", v));
         tick();
      end

      // ---- Two words back-to-back: A5 then 3C, 16 bits with no gap ----
      seq       = {8'h00, 8'hA5, 8'h3C};
      din       = 8'hA5;
      din_valid = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         check($sformatf("b2b k%0d m_x", k), m_x, seq[15-k]);
         check($sformatf("b2b k%0d l_x", k), l_x, seq[15-k]);
         check($sformatf("b2b k%0d x_valid", k), m_xv, 1'b1);
         check($sformatf("b2b k%0d word_end", k), m_we, (k == 7) || (k == 15));
         if (k == 0) begin
            check("b2b k0 din_ready", m_ready, 1'b1);
            din       = 8'h3C;
            din_valid = 1'b1;
         end else begin
            din_valid = 1'b0;
         end
         if (k == 1) check("b2b k1 din_ready", m_ready, 1'b0);
         if (k == 7) check("b2b k7 din_ready", m_ready, 1'b0);
         if (k == 8) check("b2b k8 din_ready", m_ready, 1'b1);
         tick();
      end
      check_idle("b2b after");
      tick();

      // ---- Three words with din_valid held high ----
      seq       = {8'h5A, 8'hF0, 8'h0F};
      din       = 8'h5A;
      din_valid = 1'b1;
      tick();
      for (int k = 0; k < 24; k++) begin
         check($sformatf("tri k%0d m_x", k), m_x, seq[23-k]);
         check($sformatf("tri k%0d x_valid", k), m_xv, 1'b1);
         check($sformatf("tri k%0d word_end", k), m_we, (k == 7) || (k == 15) || (k == 23));
         if (k == 0) check("tri k0 din_ready", m_ready, 1'b1);
         if (k == 1) check("tri k1 din_ready", m_ready, 1'b0);
         if (k == 7) check("tri k7 din_ready", m_ready, 1'b0);
         if (k == 8) check("tri k8 din_ready", m_ready, 1'b1);
         if (k == 9) check("tri k9 din_ready", m_ready, 1'b0);
         if (k == 16) check("tri k16 din_ready", m_ready, 1'b1);
         if (k == 0) din = 8'hF0;
         if (k == 1) din = 8'h0F;
         if (k == 9) begin
            din       = 8'h00;
            din_valid = 1'b0;
         end
         tick();
      end
      check_idle("tri after");
      tick();

      // ---- Accept on the last bit with hold empty: direct load, hold stays empty ----
      seq       = {8'h00, 8'hC1, 8'h3E};
      din       = 8'hC1;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("direct k%0d m_x", k), m_x, seq[15-k]);
         check($sformatf("direct k%0d x_valid", k), m_xv, 1'b1);
         check($sformatf("direct k%0d word_end", k), m_we, (k == 7) || (k == 15));
         if (k == 7) begin
            din       = 8'h3E;
            din_valid = 1'b1;
         end else begin
            din_valid = 1'b0;
         end
         if (k == 8) check("direct k8 din_ready", m_ready, 1'b1);
         tick();
      end
      check_idle("direct after");
      tick();

      // ---- Reset during bit 4 of FF with 00 in hold ----
      din       = 8'hFF;
      din_valid = 1'b1;
      tick();
      din       = 8'h00;  // captured into hold at the next edge
      tick();
      din_valid = 1'b0;
      check("rst-mid hold full", m_ready, 1'b0);
      tick();
      tick();
      check("rst-mid bit4 x_valid", m_xv, 1'b1);
      check("rst-mid bit4 x", m_x, 1'b1);
      reset = 1'b1;
      tick();
      check_idle("rst-mid reset cycle");
      check("rst-mid din_ready", m_ready, 1'b0);
      reset = 1'b0;
      #1;
      check("rst-mid din_ready after", m_ready, 1'b1);
      for (int k = 0; k < 20; k++) begin
         tick();
         check_idle($sformatf("rst-mid drained k%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
